// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared opcodes, FSM states and datapath select encodings for the multi-cycle RV32I controller
package riscv_ctrl_pkg;
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR,
    ST_EXEC_R, ST_EXEC_I, ST_ALUWB, ST_BRANCH, ST_JAL, ST_JALR
  } state_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_BR, ALU_FUNCT, ALU_JAL} alu_op_t;
  typedef enum logic [1:0] {SRCA_PC, SRCA_OLDPC, SRCA_RS1} src_a_t;
  typedef enum logic [1:0] {SRCB_RS2, SRCB_FOUR, SRCB_IMM} src_b_t;
  typedef enum logic [1:0] {RES_ALUOUT, RES_MDR, RES_LINK} result_t;
  // Unknown opcodes map to FETCH, which doubles as the illegal-instruction marker.
  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      LW, SW:  return ST_MEMADR;
      R_TYPE:  return ST_EXEC_R;
      I_TYPE:  return ST_EXEC_I;
      BR:      return ST_BRANCH;
      JAL:     return ST_JAL;
      JALR:    return ST_JALR;
      default: return ST_FETCH;
    endcase
  endfunction
  function automatic logic known_op(input logic [6:0] op);
    return decode_next(op) != ST_FETCH;
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive memory wait cycles and flags the cycle that reaches MEM_TIMEOUT-1
//   clk, reset : clock and asynchronous active-high reset
//   clr        : restart the count (state change or abort)
//   en         : a wait cycle (memory state with no ready)
//   timeout    : this wait cycle is the last one allowed
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  logic [7:0] cnt_q, cnt_d;
  assign timeout = en && cnt_q == 8'(MEM_TIMEOUT - 1);
  always_comb cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM sequencing the shared ALU and unified memory for RV32I
//   inputs : clk, reset (async, active-high), Opcode, BrTaken, MemReady
//   outputs: PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
//            ALUOp, PCSrc, MemErr/IllegalInstr pulses, InstrRetired counter
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             BrTaken,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             PCSrc,
  output logic             MemErr,
  output logic             IllegalInstr,
  output logic [CNT_W-1:0] InstrRetired
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic waiting, timeout, retire;
  assign waiting = state_q inside {ST_FETCH, ST_MEMRD, ST_MEMWR};
  // A FETCH timeout stays in FETCH, so the abort itself must also restart the count.
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_d != state_q || timeout),
    .en      (waiting && !MemReady),
    .timeout (timeout)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:             state_d = MemReady ? ST_DECODE : ST_FETCH;
      ST_DECODE:            state_d = decode_next(Opcode);
      ST_MEMADR:            state_d = Opcode == SW ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:             state_d = MemReady ? ST_MEMWB : timeout ? ST_FETCH : ST_MEMRD;
      ST_MEMWR:             state_d = (MemReady || timeout) ? ST_FETCH : ST_MEMWR;
      ST_EXEC_R, ST_EXEC_I: state_d = ST_ALUWB;
      default:              state_d = ST_FETCH;
    endcase
  end
  assign retire = state_q inside {ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JAL, ST_JALR} ||
                  (state_q == ST_MEMWR && MemReady);
  always_comb retired_d = retired_q + CNT_W'(retire);
  assign InstrRetired = retired_q;
  always_comb begin
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    ALUOp        = ALU_ADD;
    PCSrc        = 1'b0;
    MemErr       = 1'b0;
    IllegalInstr = 1'b0;
    if (!reset) begin
      MemErr = timeout;
      case (state_q)
        ST_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        ST_DECODE: begin
          ALUSrcA      = SRCA_OLDPC;
          ALUSrcB      = SRCB_IMM;
          IllegalInstr = !known_op(Opcode);
        end
        ST_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
        end
        ST_MEMRD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        ST_MEMWB: begin
          RegWrite  = 1'b1;
          ResultSrc = RES_MDR;
        end
        ST_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        ST_EXEC_R: begin
          ALUSrcA = SRCA_RS1;
          ALUOp   = ALU_FUNCT;
        end
        ST_EXEC_I: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_FUNCT;
        end
        ST_ALUWB: RegWrite = 1'b1;
        ST_BRANCH: begin
          ALUSrcA = SRCA_RS1;
          ALUOp   = ALU_BR;
          PCSrc   = 1'b1;
          PCWrite = BrTaken;
        end
        ST_JAL: begin
          RegWrite  = 1'b1;
          ResultSrc = RES_LINK;
          PCSrc     = 1'b1;
          PCWrite   = 1'b1;
          ALUOp     = ALU_JAL;
        end
        ST_JALR: begin
          ALUSrcA   = SRCA_RS1;
          ALUSrcB   = SRCB_IMM;
          ALUOp     = ALU_JAL;
          PCWrite   = 1'b1;
          RegWrite  = 1'b1;
          ResultSrc = RES_LINK;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction streams checked cycle by cycle against a trace-building model
module tb_multicycle_controller;
  localparam int T = 4;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] Opcode = '0;
  logic BrTaken = 1'b0, MemReady = 1'b0;
  logic PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, PCSrc, MemErr, IllegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [31:0] InstrRetired;
  logic [16:0] obs;
  int total = 0, bad = 0;
  int unsigned exp_ret = 0;
  multicycle_controller #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .BrTaken(BrTaken), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .MemErr(MemErr), .IllegalInstr(IllegalInstr),
    .InstrRetired(InstrRetired)
  );
  always #5 clk = ~clk;
  assign obs = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUOp, PCSrc, MemErr, IllegalInstr};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [16:0] cw(input int pcw, input int irw, input int iord, input int mrd,
                                     input int mwr, input int rw, input int rs, input int sa,
                                     input int sb, input int op, input int pcs, input int me,
                                     input int ill);
    return {1'(pcw), 1'(irw), 1'(iord), 1'(mrd), 1'(mwr), 1'(rw), 2'(rs), 2'(sa), 2'(sb),
            2'(op), 1'(pcs), 1'(me), 1'(ill)};
  endfunction
  task automatic step(input string tag, input logic mr, input logic [16:0] exp);
    MemReady = mr;
    @(negedge clk);
    check(tag, 64'(obs), 64'(exp));
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input int k);
    for (int j = 0; j < k; j++)
      step("fetch_wait", 1'b0, cw(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, int'((j + 1) % T == 0), 0));
    step("fetch", 1'b1, cw(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
  endtask
  task automatic mem(input int wr, input int k, output logic ok);
    int n;
    n = k < T ? k : T;
    for (int j = 0; j < n; j++)
      step("mem_wait", 1'b0, cw(0, 0, 1, 1 - wr, wr, 0, 0, 0, 0, 0, 0, int'(j == T - 1), 0));
    ok = k < T;
    if (ok) step("mem_done", 1'b1, cw(0, 0, 1, 1 - wr, wr, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic bt);
    logic ok;
    logic known;
    Opcode = op;
    BrTaken = bt;
    known = op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR};
    fetch(fw);
    step("decode", 1'($urandom), cw(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, int'(!known)));
    if (op == OP_LW || op == OP_SW) begin
      step("memadr", 1'($urandom), cw(0, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0));
      mem(int'(op == OP_SW), mw, ok);
      if (ok && op == OP_LW) step("memwb", 1'($urandom), cw(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      if (ok) exp_ret++;
    end else if (op == OP_R || op == OP_I) begin
      step("exec", 1'($urandom), cw(0, 0, 0, 0, 0, 0, 0, 2, op == OP_I ? 2 : 0, 2, 0, 0, 0));
      step("aluwb", 1'($urandom), cw(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      exp_ret++;
    end else if (op == OP_BR) begin
      step("branch", 1'($urandom), cw(int'(bt), 0, 0, 0, 0, 0, 0, 2, 0, 1, 1, 0, 0));
      exp_ret++;
    end else if (op == OP_JAL) begin
      step("jal", 1'($urandom), cw(1, 0, 0, 0, 0, 1, 2, 0, 0, 3, 1, 0, 0));
      exp_ret++;
    end else if (op == OP_JALR) begin
      step("jalr", 1'($urandom), cw(1, 0, 0, 0, 0, 1, 2, 2, 2, 3, 0, 0, 0));
      exp_ret++;
    end
    check("retired", 64'(InstrRetired), 64'(exp_ret));
  endtask
  initial begin
    logic [6:0] ops[9] = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, 7'h7F, 7'h00};
    #2;
    check("reset_outs", 64'(obs), 64'(0));
    check("reset_retired", 64'(InstrRetired), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_instr(OP_I, 0, 0, 1'b0);
    run_instr(OP_LW, 0, 3, 1'b0);
    run_instr(OP_BR, 0, 0, 1'b0);
    run_instr(OP_BR, 0, 0, 1'b1);
    run_instr(OP_SW, 0, 6, 1'b0);
    run_instr(7'h7F, 0, 0, 1'b0);
    run_instr(OP_R, 4, 0, 1'b0);
    run_instr(OP_SW, 3, 3, 1'b0);
    run_instr(OP_LW, 9, 4, 1'b1);
    for (int i = 0; i < 250; i++) begin
      int fw, mw;
      fw = $urandom_range(0, 9) > 7 ? $urandom_range(3, 9) : $urandom_range(0, 2);
      mw = $urandom_range(0, 9) > 6 ? $urandom_range(3, 6) : $urandom_range(0, 2);
      run_instr(ops[$urandom_range(0, 8)], fw, mw, 1'($urandom));
    end
    Opcode = OP_JALR;
    fetch(0);
    step("decode", 1'b0, cw(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
    @(negedge clk);
    check("jalr_pre_reset", 64'(obs), 64'(cw(1, 0, 0, 0, 0, 1, 2, 2, 2, 3, 0, 0, 0)));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outs", 64'(obs), 64'(0));
    check("async_reset_retired", 64'(InstrRetired), 64'(0));
    exp_ret = 0;
    @(posedge clk);
    @(negedge clk);
    check("held_reset_outs", 64'(obs), 64'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_instr(OP_JAL, 0, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle main control FSM for the RV32I core subset (R-type, I-type ALU, lw, sw, branch, jal, jalr).
- Sequences one shared ALU and one unified memory through fetch, decode, execute, memory and writeback steps.
- Waits on a memory-ready handshake, with a timeout.
- Sits beside the multi-cycle datapath and drives all of its mux selects and write enables. Also counts retired instructions.

Parameters:
MEM_TIMEOUT, 16, maximum cycles spent waiting for mem_ready in any memory state before aborting (legal range 2..255).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
Opcode  in  7  opcode of the instruction register (valid from DECODE onward)
BrTaken  in  1  branch comparator result (from the ALU, valid in BRANCH state)
MemReady  in  1  memory has completed the current read/write this cycle
PCWrite  out  1  load the PC
IRWrite  out  1  load the instruction register (and latch OldPC)
IorD  out  1  0: memory address = PC; 1: memory address = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
RegWrite  out  1  register file write enable
ResultSrc  out  2  00 ALUOut, 01 memory data register, 10 OldPC+4 (link)
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
ALUSrcB  out  2  00 rs2, 01 constant 4, 10 immediate
ALUOp  out  2  00 add, 01 branch compare, 10 funct decode, 11 jal
PCSrc  out  1  0 ALU result, 1 ALUOut
MemErr  out  1  one-cycle pulse on memory timeout
IllegalInstr  out  1  one-cycle pulse on unknown opcode
InstrRetired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (async, active-high):
  - state = FETCH, wait counter = 0, InstrRetired = 0.
  - All outputs are 0 while reset is held.
  - Reset mid-instruction abandons it; no partial PC/register writes after reset deasserts.
- Outputs are a Moore function of state, except the FETCH and memory-state enables gated by MemReady (listed below). Unlisted outputs are 0 in every state.
- FETCH: IorD=0, MemRead=1, ALUSrcA=00, ALUSrcB=01, ALUOp=00.
  - When MemReady=1: IRWrite=1, PCWrite=1, PCSrc=0 (PC <= PC+4), go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=10, ALUOp=00 (ALUOut <= branch/jal target). Next state by Opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - any other opcode → FETCH with IllegalInstr=1 for one cycle; counter not incremented.
- MEMADR: ALUSrcA=10, ALUSrcB=10, ALUOp=00. Go to MEMRD if lw, MEMWR if sw.
- MEMRD: IorD=1, MemRead=1. On MemReady go to MEMWB.
- MEMWB: RegWrite=1, ResultSrc=01. Retire, then FETCH.
- MEMWR: IorD=1, MemWrite=1. On MemReady retire, then FETCH.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- EXEC_I: ALUSrcA=10, ALUSrcB=10, ALUOp=10. Go to ALUWB.
- ALUWB: RegWrite=1, ResultSrc=00. Retire, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=BrTaken. Retire, then FETCH.
- JAL: RegWrite=1, ResultSrc=10, PCSrc=1, PCWrite=1, ALUOp=11. Retire, then FETCH.
- JALR: ALUSrcA=10, ALUSrcB=10, ALUOp=11, PCSrc=0, PCWrite=1, RegWrite=1, ResultSrc=10. Retire, then FETCH.
- Retire: InstrRetired increments on the cycle leaving the final state of an instruction. It wraps modulo 2^CNT_W with no flag.
- Wait counter:
  - Counts consecutive cycles in FETCH, MEMRD or MEMWR with MemReady=0. Cleared on any state change.
  - When it reaches MEM_TIMEOUT-1 and MemReady is still 0: MemErr=1 for that cycle, go to FETCH. No write enable asserts; the instruction is not retired.
  - A timeout in FETCH re-fetches the same PC.
  - If MemReady=1 on the timeout cycle, MemReady wins and there is no error.
- Latency, zero-wait memory:
  - lw: 5 cycles
  - sw: 4 cycles
  - R/I: 4 cycles
  - branch, jal, jalr: 3 cycles each

Decomposition:
- Shared package `riscv_ctrl_pkg`:
  - opcode localparams (R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR)
  - `state_t` enum
  - ALUOp, ALUSrcA/B and ResultSrc encodings as typedef'd enums or localparams
- One natural sub-module, `mem_wait_timer`: the wait counter with clear/enable inputs and a timeout output. The FSM instantiates it.

Test Plan:
1. Reset, then an addi with MemReady tied to 1 → states FETCH, DECODE, EXEC_I, ALUWB, FETCH. RegWrite=1 only in cycle 4; InstrRetired=1.
2. lw with MemReady low for 3 cycles in MEMRD → MEMRD held 4 cycles. RegWrite with ResultSrc=01 exactly once; total 8 cycles; MemErr=0.
3. beq with BrTaken=0, then beq with BrTaken=1 → PCWrite in BRANCH is 0, then 1 with PCSrc=1. Both retire; InstrRetired=2.
4. MEM_TIMEOUT=4, MemReady held 0 in MEMWR → MemErr pulses on the 4th wait cycle, then FETCH. MemWrite drops; InstrRetired unchanged.
5. Opcode 7'b1111111 in DECODE → IllegalInstr pulses once, next state FETCH. No RegWrite/PCWrite in that cycle.
6. Assert reset asynchronously mid-JALR → all outputs 0 immediately; state returns to FETCH after release. InstrRetired=0.
